inst_mem_arb: RTL

Arbiter and boot sequencer for the single-port instruction memory. It shares one synchronous-read memory port between two requesters: the core fetch stage (IF) and the program loader (LD). After reset it holds the core in a boot phase, during which only the loader may access memory. It then moves to a run phase that round-robins between fetch and loader. It sits between the IF stage and loader on one side and the memory macro on the other.

---
 rtl/inst_mem_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_arb.sv
// Instruction memory arbiter and boot sequencer: shares one synchronous-read memory port
// between the core fetch stage and the program loader, with a loader-only boot phase.
module inst_mem_arb #(
  parameter int unsigned    AW      = 10,
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  NOP     = 32'h0000_0013,
  parameter bit             BOOT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch requester
  input  logic          if_req_i,
  input  logic [DW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_err_o,
  // loader requester
  input  logic          ld_req_i,
  input  logic          ld_we_i,
  input  logic [DW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  input  logic          ld_done_i,
  output logic          ld_gnt_o,
  output logic          ld_rvalid_o,
  output logic [DW-1:0] ld_rdata_o,
  // memory port
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  // boot status
  output logic          cpu_hold_o,
  output logic [AW:0]   ld_cnt_o
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic        last_if_q, last_if_d;  // 1 = fetch was granted last, 0 = loader
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_if_q, rsp_if_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_we_q, rsp_we_d;
  logic [AW:0] ld_cnt_q, ld_cnt_d;

  logic if_addr_err, ld_addr_err;

  assign if_addr_err = (|if_addr_i[1:0]) || (|if_addr_i[DW-1:AW+2]);
  assign ld_addr_err = (|ld_addr_i[1:0]) || (|ld_addr_i[DW-1:AW+2]);

  // Grant generation and memory port drive
  always_comb begin
    if_gnt_o    = 1'b0;
    ld_gnt_o    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    if (state_q == StBoot) begin
      ld_gnt_o = ld_req_i;
    end else if (if_req_i && ld_req_i) begin
      if (last_if_q) ld_gnt_o = 1'b1;
      else           if_gnt_o = 1'b1;
    end else begin
      if_gnt_o = if_req_i;
      ld_gnt_o = ld_req_i;
    end

    if (if_gnt_o && !if_addr_err) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i[AW+1:2];
    end else if (ld_gnt_o && !ld_addr_err) begin
      mem_en_o   = 1'b1;
      mem_addr_o = ld_addr_i[AW+1:2];
      if (ld_we_i) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = ld_wdata_i;
      end
    end
  end

  // Next-state: phase, round-robin pointer, response select, load counter
  always_comb begin
    state_d     = state_q;
    last_if_d   = last_if_q;
    ld_cnt_d    = ld_cnt_q;
    rsp_valid_d = if_gnt_o || ld_gnt_o;
    rsp_if_d    = if_gnt_o;
    rsp_err_d   = if_gnt_o ? if_addr_err : (ld_gnt_o && ld_addr_err);
    rsp_we_d    = ld_gnt_o && ld_we_i;

    if (if_gnt_o)      last_if_d = 1'b1;
    else if (ld_gnt_o) last_if_d = 1'b0;

    if (state_q == StBoot) begin
      if (ld_done_i) state_d = StRun;
      // Saturate at 2^AW: the top bit set means the counter is full.
      if (ld_gnt_o && ld_we_i && !ld_addr_err && !ld_cnt_q[AW]) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT_EN ? StBoot : StRun;
      last_if_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_if_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      ld_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_if_q   <= last_if_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_if_q    <= rsp_if_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      ld_cnt_q    <= ld_cnt_d;
    end
  end

  // Response routing to the owner captured at grant
  always_comb begin
    if_rvalid_o = rsp_valid_q && rsp_if_q;
    ld_rvalid_o = rsp_valid_q && !rsp_if_q;
    if_err_o    = if_rvalid_o && rsp_err_q;
    if_rdata_o  = '0;
    ld_rdata_o  = '0;
    if (if_rvalid_o) begin
      if_rdata_o = rsp_err_q ? NOP : mem_rdata_i;
    end
    if (ld_rvalid_o && !rsp_err_q && !rsp_we_q) begin
      ld_rdata_o = mem_rdata_i;
    end
  end

  assign cpu_hold_o = (state_q == StBoot);
  assign ld_cnt_o   = ld_cnt_q;

endmodule
